// File: rtl/fifo_access_sched.sv
`default_nettype none
// fifo_access_sched: one FIFO op per cycle, round-robin writers, read/write alternation on ties.
// Optional FIFO_SCHED_STATS_EN adds per-writer/read grant counters.  Revision: 1.0
module fifo_access_sched #(
  parameter int NUM_WR = 4,
  parameter int DW     = 8,
  parameter int SW     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WR-1:0]    wr_req,
  input  logic [NUM_WR*DW-1:0] wr_data,
  output logic [NUM_WR-1:0]    wr_ack,
  input  logic                 rd_req,
  output logic                 rd_ack,
  output logic                 rd_valid,
  output logic [DW-1:0]        rd_data,
  output logic                 fifo_wr_en,
  output logic                 fifo_rd_en,
  output logic [DW-1:0]        fifo_din,
  input  logic [DW-1:0]        fifo_dout,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  input  logic [3:0]           stat_sel,
  output logic [SW-1:0]        stat_cnt
);

  localparam int PW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  op_t           last_op, last_op_next;
  logic [PW-1:0] rr_ptr, rr_ptr_next;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] scan_idx;
  logic          grant_found;
  logic          wr_cand, rd_cand;
  logic          do_write, do_read;
  logic          rd_valid_q;

  assign wr_cand = (|wr_req) && !fifo_full;
  assign rd_cand = rd_req && !fifo_empty;

  // Search starts one past the last granted producer.
  always_comb begin
    grant_idx   = rr_ptr;
    grant_found = 1'b0;
    scan_idx    = '0;
    for (int k = 1; k <= NUM_WR; k++) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NUM_WR);
      if (!grant_found && wr_req[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    do_write = 1'b0;
    do_read  = 1'b0;
    if (!reset) begin
      if (wr_cand && rd_cand) begin
        do_write = (last_op == OP_READ);
        do_read  = (last_op == OP_WRITE);
      end else begin
        do_write = wr_cand && grant_found;
        do_read  = rd_cand;
      end
    end
  end

  always_comb begin
    wr_ack   = '0;
    fifo_din = '0;
    if (do_write) begin
      wr_ack[grant_idx] = 1'b1;
      fifo_din          = wr_data[int'(grant_idx)*DW +: DW];
    end
  end

  assign fifo_wr_en = do_write;
  assign fifo_rd_en = do_read;
  assign rd_ack     = do_read;

  always_comb begin
    rr_ptr_next  = rr_ptr;
    last_op_next = last_op;
    if (do_write) begin
      rr_ptr_next  = grant_idx;
      last_op_next = OP_WRITE;
    end else if (do_read) begin
      last_op_next = OP_READ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= PW'(NUM_WR - 1);
      last_op    <= OP_READ;
      rd_valid_q <= 1'b0;
    end else begin
      rr_ptr     <= rr_ptr_next;
      last_op    <= last_op_next;
      rd_valid_q <= do_read;
    end
  end

  // Masking with reset suppresses a read return that lands in a reset cycle.
  assign rd_valid = rd_valid_q && !reset;
  assign rd_data  = rd_valid ? fifo_dout : '0;

`ifdef FIFO_SCHED_STATS_EN
  logic [SW-1:0] counters [NUM_WR+1];
  logic [SW-1:0] stat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= NUM_WR; i++) counters[i] <= '0;
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_ack[i] && (counters[i] != {SW{1'b1}})) counters[i] <= counters[i] + 1'b1;
      end
      if (rd_ack && (counters[NUM_WR] != {SW{1'b1}}))
        counters[NUM_WR] <= counters[NUM_WR] + 1'b1;
      if (int'(stat_sel) <= NUM_WR) stat_q <= counters[stat_sel];
      else                          stat_q <= '0;
    end
  end

  assign stat_cnt = stat_q;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_access_sched.sv
`default_nettype none
// tb_fifo_access_sched: directed checks of the scheduler against a 16-deep behavioural FIFO.
// Revision: 1.0
module tb_fifo_access_sched;

  localparam int NUM_WR = 4;
  localparam int DW     = 8;
  localparam int SW     = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_WR-1:0]    wr_req;
  logic [NUM_WR*DW-1:0] wr_data;
  logic [NUM_WR-1:0]    wr_ack;
  logic                 rd_req, rd_ack, rd_valid;
  logic [DW-1:0]        rd_data;
  logic                 fifo_wr_en, fifo_rd_en;
  logic [DW-1:0]        fifo_din, fifo_dout;
  logic                 fifo_full, fifo_empty;
  logic [3:0]           stat_sel;
  logic [SW-1:0]        stat_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fifo_access_sched #(.NUM_WR(NUM_WR), .DW(DW), .SW(SW)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_din(fifo_din),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  // Behavioural sync FIFO: registered dout, updated on the edge that consumes rd_en.
  logic [DW-1:0] mem [16];
  logic [3:0]    wp, rp;
  int            occ;

  always @(posedge clk) begin
    if (reset) begin
      wp <= '0; rp <= '0; occ <= 0; fifo_dout <= '0;
    end else begin
      if (fifo_wr_en && occ < 16) begin mem[wp] <= fifo_din; wp <= wp + 4'd1; end
      if (fifo_rd_en && occ > 0)  begin fifo_dout <= mem[rp]; rp <= rp + 4'd1; end
      occ <= occ + ((fifo_wr_en && occ < 16) ? 1 : 0) - ((fifo_rd_en && occ > 0) ? 1 : 0);
    end
  end

  assign fifo_full  = (occ == 16);
  assign fifo_empty = (occ == 0);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; wr_req = '0; rd_req = 1'b0; stat_sel = '0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; wr_req = 4'b1111; rd_req = 1'b1; stat_sel = 4'd0;
    wr_data = {8'h13, 8'h12, 8'h11, 8'h10};
    tick; tick;
    @(negedge clk);
    total_cnt++; if (wr_ack !== 4'b0000) $display("FAIL reset_wr_ack got %b want 0000", wr_ack); else pass_cnt++;
    total_cnt++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); else pass_cnt++;
    total_cnt++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid); else pass_cnt++;
    total_cnt++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got %h want 00", rd_data); else pass_cnt++;
    total_cnt++; if (stat_cnt !== 4'h0) $display("FAIL reset_stat_cnt got %h want 0", stat_cnt); else pass_cnt++;
    tick;
    reset = 1'b0; wr_req = '0; rd_req = 1'b0;
  endtask

  task automatic test_read_order;
    apply_reset;
    wr_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    wr_req  = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total_cnt++; if (wr_ack !== (4'b0001 << c)) $display("FAIL rdord_wr_ack[%0d] got %b want %b", c, wr_ack, 4'b0001 << c); else pass_cnt++;
      total_cnt++; if (fifo_din !== (8'hA0 + 8'(c))) $display("FAIL rdord_din[%0d] got %h want %h", c, fifo_din, 8'hA0 + 8'(c)); else pass_cnt++;
      tick;
    end
    wr_req = '0; rd_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total_cnt++; if (rd_ack !== (c < 4)) $display("FAIL rdord_rd_ack[%0d] got %b want %b", c, rd_ack, (c < 4)); else pass_cnt++;
      total_cnt++; if (rd_valid !== (c >= 1 && c <= 4)) $display("FAIL rdord_rd_valid[%0d] got %b want %b", c, rd_valid, (c >= 1 && c <= 4)); else pass_cnt++;
      if (c >= 1 && c <= 4) begin
        total_cnt++; if (rd_data !== (8'hA0 + 8'(c - 1))) $display("FAIL rdord_rd_data[%0d] got %h want %h", c, rd_data, 8'hA0 + 8'(c - 1)); else pass_cnt++;
      end
      tick;
    end
    rd_req = 1'b0;
  endtask

  task automatic test_rr_order;
    apply_reset;
    wr_data = {8'h13, 8'h12, 8'h11, 8'h10};
    wr_req  = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total_cnt++; if (wr_ack !== (4'b0001 << (c % 4))) $display("FAIL rr_wr_ack[%0d] got %b want %b", c, wr_ack, 4'b0001 << (c % 4)); else pass_cnt++;
      total_cnt++; if (fifo_din !== (8'h10 + 8'(c % 4))) $display("FAIL rr_din[%0d] got %h want %h", c, fifo_din, 8'h10 + 8'(c % 4)); else pass_cnt++;
      tick;
    end
  endtask

  task automatic test_full;
    for (int c = 0; c < 8; c++) tick;  // eight more writes fill the FIFO
    wr_req = 4'b0001; rd_req = 1'b0;
    @(negedge clk);
    total_cnt++; if (wr_ack !== 4'b0000) $display("FAIL full_wr_ack got %b want 0000", wr_ack); else pass_cnt++;
    total_cnt++; if (fifo_wr_en !== 1'b0) $display("FAIL full_wr_en got %b want 0", fifo_wr_en); else pass_cnt++;
    tick;
    rd_req = 1'b1;
    @(negedge clk);
    total_cnt++; if (rd_ack !== 1'b1) $display("FAIL full_rd_ack got %b want 1", rd_ack); else pass_cnt++;
    total_cnt++; if (fifo_wr_en !== 1'b0) $display("FAIL full_rd_wr_en got %b want 0", fifo_wr_en); else pass_cnt++;
    tick;
    rd_req = 1'b0;
    @(negedge clk);
    total_cnt++; if (wr_ack !== 4'b0001) $display("FAIL full_after_wr_ack got %b want 0001", wr_ack); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b1) $display("FAIL full_rd_valid got %b want 1", rd_valid); else pass_cnt++;
    total_cnt++; if (rd_data !== 8'h10) $display("FAIL full_rd_data got %h want 10", rd_data); else pass_cnt++;
    tick;
    wr_req = '0;
  endtask

  task automatic test_alternate;
    rd_req = 1'b1;
    for (int c = 0; c < 12; c++) tick;  // drain 16 -> 4
    wr_req = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total_cnt++; if (fifo_wr_en !== (c % 2 == 0)) $display("FAIL alt_wr_en[%0d] got %b want %b", c, fifo_wr_en, (c % 2 == 0)); else pass_cnt++;
      total_cnt++; if (fifo_rd_en !== (c % 2 == 1)) $display("FAIL alt_rd_en[%0d] got %b want %b", c, fifo_rd_en, (c % 2 == 1)); else pass_cnt++;
      total_cnt++; if (wr_ack !== ((c % 2 == 1) ? 4'b0000 : ((c % 4 == 0) ? 4'b0010 : 4'b0001)))
        $display("FAIL alt_wr_ack[%0d] got %b", c, wr_ack); else pass_cnt++;
      total_cnt++; if (occ < 4 || occ > 5) $display("FAIL alt_occupancy[%0d] got %0d want 4..5", c, occ); else pass_cnt++;
      tick;
    end
    wr_req = '0; rd_req = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    rd_req = 1'b1;
    @(negedge clk);
    total_cnt++; if (rd_ack !== 1'b1) $display("FAIL midrst_rd_ack got %b want 1", rd_ack); else pass_cnt++;
    tick;
    rd_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL midrst_rd_valid got %b want 0", rd_valid); else pass_cnt++;
    tick;
    wr_req = 4'b1111;
    @(negedge clk);
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL midrst_rd_valid2 got %b want 0", rd_valid); else pass_cnt++;
    total_cnt++; if (wr_ack !== 4'b0000) $display("FAIL midrst_wr_ack got %b want 0000", wr_ack); else pass_cnt++;
    tick;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (wr_ack !== 4'b0001) $display("FAIL midrst_first_grant got %b want 0001", wr_ack); else pass_cnt++;
    tick;
  endtask

  task automatic test_drop;
    wr_req = 4'b0000;
    @(negedge clk);
    total_cnt++; if (wr_ack !== 4'b0000) $display("FAIL drop_wr_ack got %b want 0000", wr_ack); else pass_cnt++;
    total_cnt++; if (fifo_din !== 8'h00) $display("FAIL drop_din got %h want 00", fifo_din); else pass_cnt++;
    total_cnt++; if (fifo_wr_en !== 1'b0) $display("FAIL drop_wr_en got %b want 0", fifo_wr_en); else pass_cnt++;
    tick;
    wr_req = 4'b0110;
    @(negedge clk);
    total_cnt++; if (wr_ack !== 4'b0010) $display("FAIL drop_next_grant got %b want 0010", wr_ack); else pass_cnt++;
    tick;
    wr_req = '0;
  endtask

  task automatic test_stats;
    logic [SW-1:0] exp_w2, exp_rd;
`ifdef FIFO_SCHED_STATS_EN
    exp_w2 = 4'd15; exp_rd = 4'd4;
`else
    exp_w2 = 4'd0;  exp_rd = 4'd0;
`endif
    apply_reset;
    wr_data = {8'h23, 8'h22, 8'h21, 8'h20};
    wr_req = 4'b0100; rd_req = 1'b1;
    for (int c = 0; c < 8; c++) tick;   // 4 writes, 4 reads
    rd_req = 1'b0;
    for (int c = 0; c < 16; c++) tick;  // 16 more writes
    wr_req = '0;
    total_cnt++; if (occ !== 16) $display("FAIL stats_occupancy got %0d want 16", occ); else pass_cnt++;
    stat_sel = 4'd2; tick; tick;
    @(negedge clk);
    total_cnt++; if (stat_cnt !== exp_w2) $display("FAIL stats_writer2 got %0d want %0d", stat_cnt, exp_w2); else pass_cnt++;
    tick;
    stat_sel = 4'd4; tick; tick;
    @(negedge clk);
    total_cnt++; if (stat_cnt !== exp_rd) $display("FAIL stats_reads got %0d want %0d", stat_cnt, exp_rd); else pass_cnt++;
    tick;
    stat_sel = 4'd7; tick; tick;
    @(negedge clk);
    total_cnt++; if (stat_cnt !== 4'd0) $display("FAIL stats_out_of_range got %0d want 0", stat_cnt); else pass_cnt++;
    tick;
    stat_sel = 4'd0; tick; tick;
    @(negedge clk);
    total_cnt++; if (stat_cnt !== 4'd0) $display("FAIL stats_writer0 got %0d want 0", stat_cnt); else pass_cnt++;
    tick;
  endtask

  initial begin
    reset = 1'b1; wr_req = '0; rd_req = 1'b0; stat_sel = '0; wr_data = '0;
    test_reset;
    test_read_order;
    test_rr_order;
    test_full;
    test_alternate;
    test_reset_mid_read;
    test_drop;
    test_stats;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", total_cnt);
    $fatal(1);
  end

endmodule
`default_nettype wire
